// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx - source-domain transmitter for a two-phase (toggle) req/ack
// clock-domain crossing.
//
// Ports:
//   clk      source-domain clock, rising edge
//   rst      synchronous active-high reset
//   s_valid  local word offered
//   s_ready  block can accept (transfer on s_valid & s_ready)
//   s_data   local word
//   tx_data  registered word to destination domain (changes only on accept)
//   tx_req   request level, toggles once per accepted word
//   ack_a    acknowledge level from destination domain (asynchronous)
//   busy     handshake in flight
//   to_err   sticky timeout flag
//
// Optional feature macro: CDC_HS_TX_TIMEOUT_EN enables the WAIT timeout
// counter and to_err; when undefined to_err is tied low.

module cdc_hs_tx #(
  parameter int unsigned DW      = 32,
  parameter int unsigned DP      = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          ack_a,
  output logic          busy,
  output logic          to_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DP-1:0] ack_sync_q;
  logic          ack_s;
  logic          hs_done;
  logic          accept;

  // Acknowledge synchroniser; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[DP-2:0], ack_a};
    end
  end

  assign ack_s   = ack_sync_q[DP-1];
  assign hs_done = (ack_s == tx_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating s_ready on hs_done in IDLE also holds off a stale acknowledge.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready = hs_done;
        if (s_valid && hs_done) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (hs_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_req  <= 1'b0;
      tx_data <= '0;
    end else if (accept) begin
      tx_req  <= ~tx_req;
      tx_data <= s_data;
    end
  end

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int unsigned    CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);

  logic [CW-1:0] to_cnt_q;

  // to_err rises on the same edge the count lands on TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err   <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_WAIT && to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (state_q == ST_WAIT &&
          (to_cnt_q == TO_MAX || to_cnt_q == TO_MAX - 1'b1)) begin
        to_err <= 1'b1;
      end
    end
  end
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

  localparam int DW      = 32;
  localparam int DP      = 2;
  localparam int TIMEOUT = 16;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          s_valid  = 1'b0;
  logic [DW-1:0] s_data   = '0;
  logic          ack_man  = 1'b0;
  logic          auto_ack = 1'b0;
  logic [2:0]    ack_pipe = '0;
  logic          ack_a;
  logic          s_ready;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          busy;
  logic          to_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          req;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            tests     = 0;
  int            fails     = 0;
  int            pops      = 0;
  logic          req_model = 1'b0;
  logic          rst_seen;
  logic          prev_req  = 1'b0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_data = '0;

  cdc_hs_tx #(.DW(DW), .DP(DP), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .ack_a   (ack_a),
    .busy    (busy),
    .to_err  (to_err)
  );

  always #5 clk = ~clk;

  // Receiver model: acknowledge returns tx_req after three clk cycles.
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], tx_req};
  assign ack_a = auto_ack ? ack_pipe[2] : ack_man;

  always @(posedge clk) rst_seen <= rst;

  // Scoreboard side: each tx_req toggle must match the oldest pending accept,
  // and tx_data must hold while a handshake is in flight.
  always @(negedge clk) begin
    if (rst_seen === 1'b0) begin
      if (tx_req !== prev_req) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: tx_req toggled to %0b, tx_data=%h, no pending accept", tx_req, tx_data);
        end else begin
          mon_e = sb_q.pop_front();
          pops++;
          if (tx_data !== mon_e.data || tx_req !== mon_e.req) begin
            fails++;
            $display("FAIL sb_word: got data=%h req=%0b, expected data=%h req=%0b",
                     tx_data, tx_req, mon_e.data, mon_e.req);
          end
        end
      end
      if (busy === 1'b1 && prev_busy === 1'b1) begin
        tests++;
        if (tx_data !== prev_data) begin
          fails++;
          $display("FAIL data_stable: tx_data changed %h -> %h while busy", prev_data, tx_data);
        end
      end
    end
    prev_req  = tx_req;
    prev_busy = busy;
    prev_data = tx_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] w);
    req_model = ~req_model;
    sb_q.push_back({w, req_model});
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    s_valid  = 1'b0;
    repeat (3) tick();
    rst       = 1'b0;
    req_model = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    ack_man = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (tx_req !== 1'b0 || tx_data !== '0 || busy !== 1'b0 || to_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: tx_req=%0b tx_data=%h busy=%0b to_err=%0b, expected 0 0 0 0",
               tx_req, tx_data, busy, to_err);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: s_ready=%0b, expected 1", s_ready);
    end
  endtask

  task automatic test_single;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_ready_pre: s_ready=%0b, expected 1", s_ready);
    end
    s_data  = 32'hDEADBEEF;
    s_valid = 1'b1;
    push_exp(s_data);
    tick();
    s_valid = 1'b0;
    s_data  = 32'h0BADF00D;
    tests++;
    if (tx_data !== 32'hDEADBEEF || tx_req !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_launch: tx_data=%h tx_req=%0b busy=%0b s_ready=%0b, expected deadbeef 1 1 0",
               tx_data, tx_req, busy, s_ready);
    end
    repeat (4) tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL single_hold: busy=%0b, expected 1 before ack", busy);
    end
    ack_man = 1'b1;
    tick();  // edge A
    tick();  // edge A+1
    tests++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_ack_early: busy=%0b s_ready=%0b after A+1, expected 1 0", busy, s_ready);
    end
    tick();  // edge A+2
    tests++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_ack_done: busy=%0b s_ready=%0b after A+2, expected 0 1", busy, s_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words [3];
    int            i;
    int            cyc;
    int            p0;
    words = '{32'h1, 32'h2, 32'h3};
    do_reset();
    tick();
    auto_ack = 1'b1;
    i   = 0;
    cyc = 0;
    p0  = pops;
    s_valid = 1'b1;
    while (i < 3 && cyc < 100) begin
      s_data = words[i];
      if (s_ready === 1'b1) begin
        push_exp(s_data);
        i++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    tests++;
    if (i != 3) begin
      fails++;
      $display("FAIL b2b_accepts: %0d accepts within budget, expected 3", i);
    end
    cyc = 0;
    while (busy !== 1'b0 && cyc < 50) begin
      tick();
      cyc++;
    end
    repeat (10) tick();
    tests++;
    if (pops - p0 != 3 || tx_req !== 1'b1 || sb_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_final: toggles=%0d tx_req=%0b pending=%0d busy=%0b, expected 3 1 0 0",
               pops - p0, tx_req, sb_q.size(), busy);
    end
    tests++;
    if (tx_data !== 32'h3) begin
      fails++;
      $display("FAIL b2b_last_word: tx_data=%h, expected 00000003", tx_data);
    end
  endtask

  task automatic test_stale_ack;
    do_reset();
    tick();
    ack_man = 1'b1;
    tick();
    tick();
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL stale_ready: s_ready=%0b with stale ack, expected 0", s_ready);
    end
    s_data  = 32'h55AA55AA;
    s_valid = 1'b1;
    repeat (4) tick();
    tests++;
    if (busy !== 1'b0 || tx_req !== 1'b0 || tx_data !== '0) begin
      fails++;
      $display("FAIL stale_no_accept: busy=%0b tx_req=%0b tx_data=%h, expected 0 0 0",
               busy, tx_req, tx_data);
    end
    s_valid = 1'b0;
    ack_man = 1'b0;
    tick();
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL stale_release_early: s_ready=%0b one edge after ack drop, expected 0", s_ready);
    end
    tick();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL stale_release: s_ready=%0b two edges after ack drop, expected 1", s_ready);
    end
  endtask

  task automatic test_reset_mid_wait;
    s_data  = 32'hA5A5A5A5;
    s_valid = 1'b1;
    push_exp(s_data);
    tick();
    s_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || tx_data !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL midwait_launch: busy=%0b tx_data=%h, expected 1 a5a5a5a5", busy, tx_data);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || tx_req !== 1'b0 || tx_data !== '0) begin
      fails++;
      $display("FAIL midwait_reset: busy=%0b tx_req=%0b tx_data=%h, expected 0 0 0",
               busy, tx_req, tx_data);
    end
    rst       = 1'b0;
    req_model = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    logic exp_err;
    do_reset();
    tick();
    s_data  = 32'h12345678;
    s_valid = 1'b1;
    push_exp(s_data);
    tick();  // accept edge E
    s_valid = 1'b0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      tick();
      exp_err = TO_EN && (j == TIMEOUT);
      tests++;
      if (to_err !== exp_err || busy !== 1'b1) begin
        fails++;
        $display("FAIL timeout_cycle%0d: to_err=%0b busy=%0b, expected %0b 1", j, to_err, busy, exp_err);
      end
    end
    repeat (5) tick();
    tests++;
    if (to_err !== TO_EN || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_hold: to_err=%0b busy=%0b, expected %0b 1", to_err, busy, TO_EN);
    end
    ack_man = 1'b1;
    repeat (4) tick();
    tests++;
    if (to_err !== TO_EN || busy !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_after_ack: to_err=%0b busy=%0b s_ready=%0b, expected %0b 0 1",
               to_err, busy, s_ready, TO_EN);
    end
    do_reset();
    tests++;
    if (to_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: to_err=%0b after reset, expected 0", to_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_ack();
    test_reset_mid_wait();
    test_timeout();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
